// File: rtl/sccb_cfg_sequencer_if.sv
// rtl/sccb_cfg_sequencer_if.sv - init-ROM, SCCB write/read engine and status bundle for sccb_cfg_sequencer
`timescale 1ns/1ps
interface sccb_cfg_sequencer_if #(
    parameter int ROM_AW = 8
);
    logic              cfg_go;
    logic [ROM_AW-1:0] rom_idx;
    logic [15:0]       rom_entry;
    logic              wr_start;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              rd_start;
    logic [7:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              rd_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ROM_AW-1:0] err_idx;

    modport master (
        input  cfg_go, rom_entry, wr_ready, rd_data, rd_ready,
        output rom_idx, wr_start, wr_addr, wr_data, rd_start, rd_addr,
               busy, done, err, err_idx
    );

    modport slave (
        output cfg_go, rom_entry, wr_ready, rd_data, rd_ready,
        input  rom_idx, wr_start, wr_addr, wr_data, rd_start, rd_addr,
               busy, done, err, err_idx
    );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// rtl/sccb_cfg_sequencer.sv - camera init-table walker driving the SCCB write engine; SCCB_VERIFY_EN adds readback
`timescale 1ns/1ps
module sccb_cfg_sequencer #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int GAP_CYCLES  = 2_500,
    parameter int ACK_TIMEOUT = 16,
    parameter int ROM_AW      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sccb_cfg_sequencer_if.master  bus
);
    localparam int MS_CYC = CLK_FREQ / 1000;
    localparam int CW0    = $clog2(MS_CYC + 1);
    localparam int CW1    = $clog2(GAP_CYCLES + 1);
    localparam int CW2    = $clog2(ACK_TIMEOUT + 1);
    localparam int CW01   = (CW0 > CW1) ? CW0 : CW1;
    localparam int CW     = (CW01 > CW2) ? CW01 : CW2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_ISSUE  = 4'd3;
    localparam logic [3:0] S_W_ACK  = 4'd4;
    localparam logic [3:0] S_W_DONE = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;
    localparam logic [3:0] S_DELAY  = 4'd7;
    localparam logic [3:0] S_END    = 4'd8;
    localparam logic [3:0] S_ERR    = 4'd9;
`ifdef SCCB_VERIFY_EN
    localparam logic [3:0] S_V_ISSUE = 4'd10;
    localparam logic [3:0] S_V_ACK   = 4'd11;
    localparam logic [3:0] S_V_DONE  = 4'd12;
`endif

    logic [3:0]        state;
    logic [ROM_AW-1:0] idx;
    logic [7:0]        addr_q;
    logic [7:0]        data_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ROM_AW-1:0] err_idx_q;
    logic [CW-1:0]     cnt;
    logic [7:0]        ms_left;
    logic              last;

    // The table never wraps: finishing the top entry is an implicit end marker.
    assign last = &idx;

`ifdef SCCB_VERIFY_EN
    logic       rd_start_q;
    logic [7:0] rd_addr_q;
    assign bus.rd_start = rd_start_q;
    assign bus.rd_addr  = rd_addr_q;
`else
    logic unused_rd;
    assign unused_rd    = &{1'b0, bus.rd_data, bus.rd_ready};
    assign bus.rd_start = 1'b0;
    assign bus.rd_addr  = 8'h00;
`endif

    assign bus.rom_idx  = idx;
    assign bus.wr_start = start_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_idx  = err_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            cnt       <= '0;
            ms_left   <= 8'h00;
`ifdef SCCB_VERIFY_EN
            rd_start_q <= 1'b0;
            rd_addr_q  <= 8'h00;
`endif
        end else begin
            start_q <= 1'b0;
`ifdef SCCB_VERIFY_EN
            rd_start_q <= 1'b0;
`endif
            case (state)
                S_IDLE, S_END, S_ERR: begin
                    if (bus.cfg_go) begin
                        idx       <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (bus.rom_entry == 16'hFFFF) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_END;
                    end else if (bus.rom_entry[15:8] == 8'hF0) begin
                        if (bus.rom_entry[7:0] == 8'h00) begin
                            if (last) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= S_END;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_FETCH;
                            end
                        end else begin
                            ms_left <= bus.rom_entry[7:0];
                            cnt     <= '0;
                            state   <= S_DELAY;
                        end
                    end else begin
                        addr_q <= bus.rom_entry[15:8];
                        data_q <= bus.rom_entry[7:0];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.wr_ready) begin
                        start_q <= 1'b1;
                        cnt     <= '0;
                        state   <= S_W_ACK;
                    end
                end
                S_W_ACK: begin
                    if (!bus.wr_ready) begin
                        state <= S_W_DONE;
                    end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_idx_q <= idx;
                        state     <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_W_DONE: begin
                    if (bus.wr_ready) begin
                        cnt <= '0;
`ifdef SCCB_VERIFY_EN
                        state <= S_V_ISSUE;
`else
                        state <= S_GAP;
`endif
                    end
                end
`ifdef SCCB_VERIFY_EN
                S_V_ISSUE: begin
                    if (bus.rd_ready) begin
                        rd_start_q <= 1'b1;
                        rd_addr_q  <= addr_q;
                        cnt        <= '0;
                        state      <= S_V_ACK;
                    end
                end
                S_V_ACK: begin
                    if (!bus.rd_ready) begin
                        state <= S_V_DONE;
                    end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_idx_q <= idx;
                        state     <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_V_DONE: begin
                    if (bus.rd_ready) begin
                        if (bus.rd_data != data_q) begin
                            busy_q    <= 1'b0;
                            err_q     <= 1'b1;
                            err_idx_q <= idx;
                            state     <= S_ERR;
                        end else begin
                            cnt   <= '0;
                            state <= S_GAP;
                        end
                    end
                end
`endif
                S_GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        if (last) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_END;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    // cnt is the sub-millisecond tick; ms_left counts whole milliseconds remaining.
                    if (cnt == CW'(MS_CYC - 1)) begin
                        cnt <= '0;
                        if (ms_left == 8'd1) begin
                            if (last) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= S_END;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_FETCH;
                            end
                        end else begin
                            ms_left <= ms_left - 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb/tb_sccb_cfg_sequencer.sv - self-checking bench for sccb_cfg_sequencer (honours SCCB_VERIFY_EN)
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;
    localparam int CLK_FREQ = 20_000;
    localparam int MS_CYC   = CLK_FREQ / 1000;
    localparam int GAP      = 5;
    localparam int ACK_TO   = 16;
    localparam int AW       = 2;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sccb_cfg_sequencer_if #(.ROM_AW(AW)) bus();

    sccb_cfg_sequencer #(
        .CLK_FREQ(CLK_FREQ), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK_TO), .ROM_AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int go_cyc = 0;
    logic [15:0] rom [DEPTH];
    logic [7:0]  cam [256];
    int ack_dly = 3;
    int done_dly = 40;
    int hang_wr = -1;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit bad_rd_en = 1'b0;
    logic [7:0] bad_rd_addr = 8'h00;
    logic [7:0] bad_rd_val = 8'h00;
    logic [15:0] wr_log [$];
    int          wr_cyc [$];

    logic [15:0] exp_w [$];
    bit exp_done, exp_err;
    int exp_eidx, exp_idx;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Registered ROM: entry follows rom_idx by one clock.
    initial begin
        int prev;
        prev = 0;
        bus.rom_entry = 16'h0000;
        forever begin
            @(posedge clk); #1;
            bus.rom_entry = rom[prev];
            prev = int'(bus.rom_idx);
        end
    end

    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.wr_start === 1'b1) begin
                wr_log.push_back({bus.wr_addr, bus.wr_data});
                wr_cyc.push_back(cyc);
                cam[bus.wr_addr] = bus.wr_data;
                if (wr_cnt != hang_wr) begin
                    repeat (ack_dly - 1) begin @(posedge clk); #1; end
                    bus.wr_ready = 1'b0;
                    repeat (done_dly) begin @(posedge clk); #1; end
                    bus.wr_ready = 1'b1;
                end
                wr_cnt++;
            end
        end
    end

    initial begin
        logic [7:0] a;
        bus.rd_ready = 1'b1;
        bus.rd_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.rd_start === 1'b1) begin
                a = bus.rd_addr;
                rd_cnt++;
                repeat (ack_dly - 1) begin @(posedge clk); #1; end
                bus.rd_ready = 1'b0;
                repeat (done_dly) begin @(posedge clk); #1; end
                bus.rd_data  = (bad_rd_en && a == bad_rd_addr) ? bad_rd_val : cam[a];
                bus.rd_ready = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic go();
        @(negedge clk);
        bus.cfg_go = 1'b1;
        go_cyc = cyc + 1;
        @(negedge clk);
        bus.cfg_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, want 0", name, bus.busy, n);
        end
    endtask

    // Walk the table by the entry rules; what the engine should see and how the run should end.
    task automatic model(input int hang, input bit bad_en, input logic [7:0] bad_a, input logic [7:0] bad_v);
        logic [15:0] e;
        int nw;
        exp_w.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 0; exp_idx = 0; nw = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e = rom[i];
            exp_idx = i;
            if (e == 16'hFFFF) begin exp_done = 1'b1; return; end
            if (e[15:8] == 8'hF0) continue;
            exp_w.push_back(e);
            if (nw == hang) begin exp_err = 1'b1; exp_eidx = i; return; end
`ifdef SCCB_VERIFY_EN
            if (bad_en && e[15:8] == bad_a && e[7:0] != bad_v) begin exp_err = 1'b1; exp_eidx = i; return; end
`endif
            nw++;
        end
        exp_done = 1'b1;
    endtask

    task automatic test_reset();
        logic [32:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.rom_idx, bus.wr_start, bus.wr_addr, bus.wr_data, bus.rd_start,
                bus.rd_addr, bus.busy, bus.done, bus.err, bus.err_idx};
        total++;
        if (outs !== 33'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.wr_start} !== 4'b0000) begin
            bad++; $display("FAIL reset_idle: busy/done/err/start=%b want 0000", {bus.busy, bus.done, bus.err, bus.wr_start});
        end
    endtask

    task automatic test_basic();
        int d;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        ack_dly = 3; done_dly = 40; clear_logs();
        go();
        wait_idle(2000, "t1");
        total++;
        if (wr_log.size() != 2) begin bad++; $display("FAIL t1_count: got %0d want 2", wr_log.size()); end
        else begin
            total++;
            if (wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1101) begin
                bad++; $display("FAIL t1_writes: got %h %h want 1280 1101", wr_log[0], wr_log[1]);
            end
            d = wr_cyc[1] - wr_cyc[0];
            total++;
            if (d < 3 + 40 + GAP + 2 || d > 3 + 40 + GAP + 6) begin
                bad++; $display("FAIL t1_spacing: got %0d cycles want %0d..%0d", d, 3 + 40 + GAP + 2, 3 + 40 + GAP + 6);
            end
        end
        total++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
            bad++; $display("FAIL t1_status: done/busy/err=%b want 100", {bus.done, bus.busy, bus.err});
        end
    endtask

    task automatic test_delay();
        int d;
        rom[0] = 16'hF002; rom[1] = 16'h3A04; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        ack_dly = 2; done_dly = 5; clear_logs();
        go();
        wait_idle(2000, "t2");
        total++;
        if (wr_log.size() != 1 || wr_log[0] !== 16'h3A04) begin
            bad++; $display("FAIL t2_writes: got %0d writes first=%h want 1 x 3a04", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 16'h0);
        end else begin
            d = wr_cyc[0] - (go_cyc + 2);
            total++;
            if (d < 2 * MS_CYC || d > 2 * MS_CYC + 8) begin
                bad++; $display("FAIL t2_delay: got %0d cycles want %0d..%0d", d, 2 * MS_CYC, 2 * MS_CYC + 8);
            end
        end
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL t2_done: got %b want 1", bus.done); end
    endtask

    task automatic test_timeout();
        int n, ecyc;
        rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        ack_dly = 2; done_dly = 6; hang_wr = 1; clear_logs();
        go();
        n = 0;
        while (bus.err !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        ecyc = cyc;
        repeat (60) @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.err_idx !== 2'd1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL t3_status: err=%b err_idx=%0d done=%b busy=%b want 1 1 0 0", bus.err, bus.err_idx, bus.done, bus.busy);
        end
        total++;
        if (wr_log.size() != 2) begin bad++; $display("FAIL t3_count: got %0d want 2", wr_log.size()); end
        else begin
            total++;
            if (ecyc - wr_cyc[1] != ACK_TO) begin
                bad++; $display("FAIL t3_latency: got %0d want %0d", ecyc - wr_cyc[1], ACK_TO);
            end
        end
        hang_wr = -1;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [32:0] outs;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
        ack_dly = 2; done_dly = 40; clear_logs();
        go();
        n = 0;
        while (!(wr_log.size() == 2 && bus.wr_ready === 1'b0) && n < 1000) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        outs = {bus.rom_idx, bus.wr_start, bus.wr_addr, bus.wr_data, bus.rd_start,
                bus.rd_addr, bus.busy, bus.done, bus.err, bus.err_idx};
        total++;
        if (n >= 1000 || outs !== 33'd0) begin bad++; $display("FAIL t4_async_clear: got %h (wait %0d) want 0", outs, n); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        clear_logs();
        go();
        total++;
        if (bus.rom_idx !== 2'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL t4_restart: rom_idx=%0d busy=%b want 0 1", bus.rom_idx, bus.busy);
        end
        wait_idle(3000, "t4");
        total++;
        if (wr_log.size() != 3 || wr_log[0] !== 16'h1280 || bus.done !== 1'b1) begin
            bad++; $display("FAIL t4_rerun: writes=%0d done=%b want 3 1", wr_log.size(), bus.done);
        end
    endtask

    task automatic test_verify();
        rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        ack_dly = 2; done_dly = 5; bad_rd_en = 1'b1; bad_rd_addr = 8'h3A; bad_rd_val = 8'h05;
        clear_logs();
        model(-1, 1'b1, 8'h3A, 8'h05);
        go();
        wait_idle(3000, "t5");
        total++;
        if (bus.err !== exp_err || bus.done !== exp_done) begin
            bad++; $display("FAIL t5_status: err=%b done=%b want %b %b", bus.err, bus.done, exp_err, exp_done);
        end
        total++;
        if (exp_err && bus.err_idx !== exp_eidx[AW-1:0]) begin
            bad++; $display("FAIL t5_err_idx: got %0d want %0d", bus.err_idx, exp_eidx);
        end
`ifdef SCCB_VERIFY_EN
        total++;
        if (rd_cnt != 2) begin bad++; $display("FAIL t5_reads: got %0d want 2", rd_cnt); end
`else
        total++;
        if (rd_cnt != 0) begin bad++; $display("FAIL t5_reads: got %0d want 0", rd_cnt); end
`endif
        bad_rd_en = 1'b0;
    endtask

    task automatic test_no_end();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h3A04; rom[3] = 16'h55AA;
        ack_dly = 1; done_dly = 3; clear_logs();
        go();
        wait_idle(3000, "t6");
        repeat (30) @(negedge clk);
        total++;
        if (wr_log.size() != 4) begin bad++; $display("FAIL t6_count: got %0d want 4", wr_log.size()); end
        total++;
        if (bus.done !== 1'b1 || bus.rom_idx !== 2'd3) begin
            bad++; $display("FAIL t6_end: done=%b rom_idx=%0d want 1 3", bus.done, bus.rom_idx);
        end
    endtask

    task automatic test_random();
        int r, hang;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      rom[i] = 16'hFFFF;
                else if (r < 3)  rom[i] = {8'hF0, 8'($urandom_range(0, 2))};
                else             rom[i] = 16'($urandom);
            end
            ack_dly  = $urandom_range(1, 6);
            done_dly = $urandom_range(1, 15);
            hang = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            hang_wr = hang;
            clear_logs();
            model(hang, 1'b0, 8'h00, 8'h00);
            go();
            wait_idle(3000, "rnd");
            repeat (2) @(negedge clk);
            total++;
            if (wr_log.size() != exp_w.size()) begin
                bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, wr_log.size(), exp_w.size());
            end else begin
                for (int k = 0; k < exp_w.size(); k++) begin
                    total++;
                    if (wr_log[k] !== exp_w[k]) begin
                        bad++; $display("FAIL rnd%0d_write%0d: got %h want %h", it, k, wr_log[k], exp_w[k]);
                    end
                end
            end
            total++;
            if (bus.done !== exp_done || bus.err !== exp_err || bus.rom_idx !== exp_idx[AW-1:0]) begin
                bad++; $display("FAIL rnd%0d_end: done=%b err=%b rom_idx=%0d want %b %b %0d",
                                it, bus.done, bus.err, bus.rom_idx, exp_done, exp_err, exp_idx);
            end
            total++;
            if (exp_err && bus.err_idx !== exp_eidx[AW-1:0]) begin
                bad++; $display("FAIL rnd%0d_err_idx: got %0d want %0d", it, bus.err_idx, exp_eidx);
            end
            hang_wr = -1;
            if (hang >= 0) begin
                // a hung engine keeps wr_ready high, so the next run starts clean
                repeat (2) @(negedge clk);
            end
        end
    endtask

    initial begin
        bus.cfg_go = 1'b0;
        for (int i = 0; i < 256; i++) cam[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_reset_mid();
        test_verify();
        test_no_end();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
